// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control FSM (Opcode/mem_ready in; datapath selects, enables, illegal, retired out)
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  input  logic             Zero,
  output logic             Regsel,
  output logic             ALUsel,
  output logic             ALUSrcA,
  output logic [1:0]       ALUBpc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       MemWrite,
  output logic             MemRead,
  output logic             IorD,
  output logic             MemToRegSel,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  state_t           r_state, w_next;
  logic             r_hold, w_retire, w_unused;
  logic [CNT_W-1:0] r_retired;
  assign w_unused = Zero;
  assign retired  = r_retired;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_hold    <= 1'b1;
      r_retired <= '0;
    end else begin
      r_hold  <= 1'b0;
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    Regsel      = 1'b0;
    ALUsel      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUBpc      = 2'b00;
    ALUOp       = 2'b00;
    MemWrite    = 2'b00;
    MemRead     = 1'b0;
    IorD        = 1'b0;
    MemToRegSel = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    if (!r_hold) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUBpc  = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          w_next  = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUBpc = 2'b10;
          w_next = Opcode == OP_R ? S_EXEC :
                   (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                   Opcode == OP_BEQ ? S_BRANCH :
                   Opcode == OP_ADDI ? S_ADDIEX :
                   Opcode == OP_J ? S_JUMP : S_TRAP;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUsel  = 1'b1;
          w_next  = Opcode == OP_SW ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          w_next  = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite    = 1'b1;
          MemToRegSel = 1'b1;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 2'b11;
          IorD     = 1'b1;
          w_retire = mem_ready;
          w_next   = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          w_next  = S_RWB;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          Regsel   = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUsel  = 1'b1;
          w_next  = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;
  logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, Zero = 1'b0;
  logic [5:0]  Opcode = 6'h00;
  logic        Regsel, ALUsel, ALUSrcA, MemRead, IorD, MemToRegSel, RegWrite;
  logic        IRWrite, PCWrite, PCWriteCond, illegal;
  logic [1:0]  ALUBpc, ALUOp, MemWrite, PCSource;
  logic [3:0]  retired;
  logic [18:0] o_vec;
  logic [18:0] exp_q[$];
  int          ret_q[$];
  int          checks = 0, failures = 0, ret = 0;
  always #5 clk = ~clk;
  mc_control_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready), .Zero(Zero),
    .Regsel(Regsel), .ALUsel(ALUsel), .ALUSrcA(ALUSrcA), .ALUBpc(ALUBpc),
    .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead), .IorD(IorD),
    .MemToRegSel(MemToRegSel), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .illegal(illegal), .retired(retired)
  );
  assign o_vec = {Regsel, ALUsel, ALUSrcA, ALUBpc, ALUOp, MemWrite, MemRead, IorD,
                  MemToRegSel, RegWrite, IRWrite, PCWrite, PCWriteCond, PCSource, illegal};
  function automatic logic [18:0] ev(input string st, input logic mr);
    logic rs = 0, as = 0, asa = 0, mrd = 0, iod = 0, m2r = 0, rw = 0, irw = 0, pcw = 0, pcc = 0, ill = 0;
    logic [1:0] bpc = 0, op = 0, mw = 0, pcs = 0;
    case (st)
      "FETCH":  begin mrd = 1; bpc = 2'b01; irw = mr; pcw = mr; end
      "DECODE": bpc = 2'b10;
      "MEMADR": begin asa = 1; as = 1; end
      "MEMRD":  begin mrd = 1; iod = 1; end
      "MEMWB":  begin rw = 1; m2r = 1; end
      "MEMWR":  begin mw = 2'b11; iod = 1; end
      "EXEC":   begin asa = 1; op = 2'b10; end
      "RWB":    begin rw = 1; rs = 1; end
      "ADDIEX": begin asa = 1; as = 1; end
      "ADDIWB": rw = 1;
      "BRANCH": begin asa = 1; op = 2'b01; pcc = 1; pcs = 2'b01; end
      "JUMP":   begin pcw = 1; pcs = 2'b10; end
      "TRAP":   ill = 1;
      default:  ;
    endcase
    return {rs, as, asa, bpc, op, mw, mrd, iod, m2r, rw, irw, pcw, pcc, pcs, ill};
  endfunction
  task automatic chk(input string st);
    logic [18:0] e;
    int          r;
    exp_q.push_back(ev(st, mem_ready));
    ret_q.push_back(ret);
    #1;
    e = exp_q.pop_front();
    r = ret_q.pop_front();
    checks += 3;
    assert (o_vec === e) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", st, o_vec, e);
    end
    assert (retired === 4'(r)) else begin
      failures++;
      $error("FAIL %s retired observed=%0d expected=%0d", st, retired, r);
    end
    assert (!(MemRead && MemWrite != 2'b00) && !(RegWrite && (PCWrite || PCWriteCond))) else begin
      failures++;
      $error("FAIL %s exclusivity observed=%h expected=no_overlap", st, o_vec);
    end
    @(negedge clk);
  endtask
  task automatic retire();
    ret = (ret + 1) % 16;
  endtask
  initial begin
    @(negedge clk);
    chk("ZERO");
    chk("ZERO");
    rst = 1'b0;
    chk("ZERO");
    chk("FETCH");
    mem_ready = 1'b1;
    Opcode = 6'h00;
    chk("FETCH"); chk("DECODE"); chk("EXEC"); chk("RWB"); retire();
    Opcode = 6'h23;
    chk("FETCH"); chk("DECODE"); chk("MEMADR");
    mem_ready = 1'b0;
    chk("MEMRD"); chk("MEMRD"); chk("MEMRD");
    mem_ready = 1'b1;
    chk("MEMRD"); chk("MEMWB"); retire();
    Opcode = 6'h2B;
    chk("FETCH"); chk("DECODE"); chk("MEMADR");
    mem_ready = 1'b0;
    chk("MEMWR"); chk("MEMWR");
    mem_ready = 1'b1;
    chk("MEMWR"); retire();
    Opcode = 6'h04;
    chk("FETCH"); chk("DECODE"); chk("BRANCH"); retire();
    Opcode = 6'h3F;
    chk("FETCH"); chk("DECODE"); chk("TRAP");
    Opcode = 6'h08;
    chk("FETCH"); chk("DECODE"); chk("ADDIEX"); chk("ADDIWB"); retire();
    Opcode = 6'h02;
    while (ret != 0) begin
      chk("FETCH"); chk("DECODE"); chk("JUMP"); retire();
    end
    chk("FETCH"); chk("DECODE"); chk("JUMP"); retire();
    Opcode = 6'h2B;
    chk("FETCH"); chk("DECODE"); chk("MEMADR");
    mem_ready = 1'b0;
    rst = 1'b1;
    chk("MEMWR");
    rst = 1'b0;
    ret = 0;
    chk("ZERO");
    chk("FETCH");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
